// File: rtl/cache_pkg.sv
// Shared cache geometry and miss-controller state encoding.
// Imported by the miss controller, its interface and the cache array.
package cache_pkg;

  localparam int NUM_SETS    = 16;
  localparam int NUM_WAYS    = 2;
  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W    = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    RESPOND
  } miss_state_t;

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// CPU-side request, cache fill port and memory handshake bundle.
// The slave modport is the controller's view; master is the environment's.
interface cache_miss_ctrl_if #(
  parameter int OFFSET_W = 2
);

  logic                cpu_req;
  logic                cpu_we;
  logic [29:0]         cpu_addr;
  logic [31:0]         cpu_wdata;
  logic                cache_hit;
  logic                stall;
  logic                cache_wr_en;
  logic                fill_en;
  logic [OFFSET_W-1:0] fill_word;
  logic [31:0]         fill_data;
  logic                fill_commit;
  logic                mem_req;
  logic                mem_we;
  logic [29:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic                mem_ack;
  logic [31:0]         mem_rdata;
  logic                err;

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    input  cache_hit,
    input  mem_ack,
    input  mem_rdata,
    output stall,
    output cache_wr_en,
    output fill_en,
    output fill_word,
    output fill_data,
    output fill_commit,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output err
  );

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    output cache_hit,
    output mem_ack,
    output mem_rdata,
    input  stall,
    input  cache_wr_en,
    input  fill_en,
    input  fill_word,
    input  fill_data,
    input  fill_commit,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  err
  );

endinterface

// File: rtl/ack_timeout_ctr.sv
// Saturating wait counter for one memory beat.
// expire fires on the LIMIT-th consecutive counted cycle.
module ack_timeout_ctr #(
  parameter int LIMIT = 255,
  localparam int CW = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != CW'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expire = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/cache_miss_ctrl.sv
// Read-miss refill and write-through sequencer for the data cache.
// Outputs decode from state plus the live CPU request while idle.
import cache_pkg::*;

module cache_miss_ctrl #(
  parameter int BLOCK_WORDS = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  cache_miss_ctrl_if.slave bus
);

  localparam int OW = $clog2(BLOCK_WORDS);
  localparam int TW = 30 - OW;
  localparam logic [OW-1:0] LAST = OW'(BLOCK_WORDS - 1);

  miss_state_t   state;
  logic [TW-1:0] tag;
  logic [OW-1:0] beat;
  logic [29:0]   waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          ack;
  logic          expire;

  assign busy = (state == REFILL) || (state == WRITE);
  assign ack  = busy && bus.mem_ack;

  ack_timeout_ctr #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!busy || bus.mem_ack),
    .en     (busy && !bus.mem_ack),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tag   <= '0;
      beat  <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cpu_req && bus.cpu_we) begin
            waddr <= bus.cpu_addr;
            wdata <= bus.cpu_wdata;
            state <= WRITE;
          end else if (bus.cpu_req && !bus.cache_hit) begin
            tag   <= bus.cpu_addr[29:OW];
            beat  <= '0;
            state <= REFILL;
          end
        end
        REFILL: begin
          if (ack) begin
            beat <= beat + 1'b1;
            if (beat == LAST) state <= RESPOND;
          end else if (expire) begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (ack) state <= RESPOND;
          else if (expire) state <= IDLE;
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Fill side effects are masked while reset is sampled so no partial line commits.
  always_comb begin
    bus.stall       = 1'b0;
    bus.cache_wr_en = 1'b0;
    bus.fill_en     = 1'b0;
    bus.fill_word   = '0;
    bus.fill_data   = '0;
    bus.fill_commit = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.err         = 1'b0;
    unique case (state)
      IDLE: begin
        bus.stall = bus.cpu_req && (bus.cpu_we || !bus.cache_hit);
        bus.cache_wr_en = bus.cpu_req && bus.cpu_we && bus.cache_hit;
      end
      REFILL: begin
        bus.stall     = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {tag, beat};
        bus.fill_word = beat;
        if (ack && !rst) begin
          bus.fill_en     = 1'b1;
          bus.fill_data   = bus.mem_rdata;
          bus.fill_commit = (beat == LAST);
        end
        bus.err = expire && !rst;
      end
      WRITE: begin
        bus.stall     = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = waddr;
        bus.mem_wdata = wdata;
        bus.err       = expire && !rst;
      end
      RESPOND: bus.stall = 1'b1;
      default: bus.stall = 1'b0;
    endcase
  end

endmodule

// File: doc/cache_miss_ctrl.md
Name: cache_miss_ctrl

Overview:
Sequencing controller for the 16-set, 2-way, 4-word-block data cache. It detects read misses, stalls the CPU, and fetches the full block from backing memory over a req/ack handshake. It streams the fetched words into the cache fill port and commits tag/valid/LRU once the block is complete. Writes are write-through with no write-allocate: the controller forwards every CPU store to memory and stalls until memory accepts it.

Parameters:
BLOCK_WORDS, 4, words per cache block (power of two, ≥2)
ACK_TIMEOUT, 255, max cycles to wait for mem_ack per beat before aborting

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU memory access valid this cycle
cpu_we  in  1  access is a store
cpu_addr  in  30  word address [31:2]
cpu_wdata  in  32  store data
cache_hit  in  1  cache lookup hit for cpu_addr (combinational from cache)
stall  out  1  freeze CPU pipeline
cache_wr_en  out  1  write cpu_wdata into the hitting way (store hit)
fill_en  out  1  write fill_data into the replacement way at fill_word
fill_word  out  $clog2(BLOCK_WORDS)  word index within block being filled
fill_data  out  32  word returned from memory
fill_commit  out  1  one-cycle pulse: set tag/valid for the captured set, update LRU
mem_req  out  1  memory request
mem_we  out  1  memory request is a write
mem_addr  out  30  memory word address
mem_wdata  out  32  memory write data
mem_ack  in  1  memory accepted request; for reads, mem_rdata valid same cycle
mem_rdata  in  32  memory read data
err  out  1  one-cycle pulse on timeout abort

Behaviour:
- States: IDLE, REFILL, WRITE, RESPOND. State, beat counter, captured address/data and timeout counter are registered. Outputs are decoded from state plus IDLE-cycle inputs.
- Reset: state=IDLE, counters=0. All outputs are 0 while in IDLE with cpu_req=0.
- IDLE, cpu_req & !cpu_we & cache_hit: no stall, no memory activity.
- IDLE, cpu_req & !cpu_we & !cache_hit:
  - stall=1 combinationally in the same cycle.
  - Capture blk_base={cpu_addr[29:log2(BLOCK_WORDS)],0}, beat=0.
  - Next state REFILL.
- IDLE, cpu_req & cpu_we:
  - stall=1 combinationally.
  - cache_wr_en=cache_hit for that cycle only.
  - Capture addr/data; next state WRITE. Write miss does not allocate.
- REFILL:
  - Outputs: stall=1, mem_req=1, mem_we=0, mem_addr=blk_base|beat. Held stable until mem_ack.
  - On mem_ack: fill_en=1, fill_word=beat, fill_data=mem_rdata; beat increments and the timeout counter clears.
  - On mem_ack with beat==BLOCK_WORDS-1: fill_commit=1 in the same cycle; next state RESPOND.
  - Fill order is always word 0 first; no critical-word-first.
  - mem_addr never carries out of the block offset bits.
- WRITE:
  - Outputs: stall=1, mem_req=1, mem_we=1, captured addr/data.
  - On mem_ack: next state RESPOND.
- RESPOND: stall=1 for one cycle so the cache lookup settles; next state IDLE. The CPU re-presents the access, which then hits for reads.
- Latency, read miss with zero-wait ack: stall high 6 consecutive cycles (detect cycle + 4 beats + RESPOND).
- Latency, store with zero-wait ack: stall high 3 cycles.
- Timeout:
  - The counter increments every cycle in REFILL/WRITE without mem_ack.
  - At ACK_TIMEOUT: err pulse, mem_req drops next cycle, no fill_commit, state goes to IDLE.
  - A partially filled line stays invalid.
- cpu_req changes while state≠IDLE are ignored, because the captured values are used.
- rst mid-operation: state returns to IDLE at that edge. No fill_commit is issued, so the cache holds no half-filled valid line. mem_req is 0 from the cycle after reset is sampled.
- mem_ack outside REFILL/WRITE is ignored.

Decomposition:
- Shared package cache_pkg:
  - NUM_SETS=16, NUM_WAYS=2, BLOCK_WORDS=4, OFFSET_W=$clog2(BLOCK_WORDS).
  - miss_state_t enum {IDLE, REFILL, WRITE, RESPOND}.
- Also used by the cache for fill port widths.
- One sub-module is natural: ack_timeout_ctr, a loadable saturating counter with clear and expire output.

Test Plan:
- Read hit: cpu_req=1, cpu_we=0, cache_hit=1 at addr 0x0000_0040 → stall=0, mem_req=0, no fill_en.
- Read miss, zero-wait ack: addr word 0x13 → mem_addr sequence 0x10, 0x11, 0x12, 0x13. Four fill_en with fill_word 0..3 and matching mem_rdata. fill_commit on the 4th beat; stall high exactly 6 cycles.
- Read miss with 2 wait cycles per beat → mem_addr held stable during waits, fill_en only on ack cycles, stall high 14 cycles.
- Store hit, data 0xDEADBEEF: cache_wr_en pulses in the detect cycle; mem_we=1, mem_wdata=0xDEADBEEF until ack; no fill_en.
- Store miss → no cache_wr_en, no fill, memory write only.
- Timeout with ACK_TIMEOUT=8, mem_ack never asserted in REFILL → err pulses once after 8 wait cycles, no fill_commit, back to IDLE.
- rst asserted after beat 2 of a refill → IDLE next cycle, mem_req=0, fill_commit never seen. A following miss restarts at word 0.
